// File: rtl/expmul_sched_pkg.sv
// Shared types for the online-softmax row scheduler: score/vector widths,
// FSM state encoding and the signed max helper.
package expmul_sched_pkg;

  localparam int INT_W   = 8;
  localparam int ELEM_W  = 8;
  localparam int VEC_LEN = 4;
  localparam int VEC_W   = ELEM_W * VEC_LEN;

  typedef logic signed [INT_W-1:0]  int_t;
  typedef logic signed [ELEM_W-1:0] elem_t;
  typedef logic [VEC_W-1:0]         v_vector_t;

  typedef enum logic [2:0] {
    ST_ACCEPT,
    ST_ISSUE_R,
    ST_WAIT_R,
    ST_ISSUE_V,
    ST_WAIT_V,
    ST_OUT
  } sched_state_e;

  function automatic int_t max_signed(input int_t a, input int_t b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/expmul_sched_vec_sat_add.sv
// Element-wise signed vector add; SAT selects clamping to the element range
// instead of two's-complement wrap.
module vec_sat_add
  import expmul_sched_pkg::*;
#(
  parameter bit SAT = 1'b1
) (
  input  logic [VEC_W-1:0] a_in,
  input  logic [VEC_W-1:0] b_in,
  output logic [VEC_W-1:0] sum_out
);

  function automatic logic [ELEM_W-1:0] add_elem(input logic [ELEM_W-1:0] x,
                                                 input logic [ELEM_W-1:0] y);
    logic [ELEM_W:0] w;
    w = {x[ELEM_W-1], x} + {y[ELEM_W-1], y};
    // Overflow shows up as the two top bits of the widened sum disagreeing.
    if (SAT && (w[ELEM_W] != w[ELEM_W-1]))
      return w[ELEM_W] ? {1'b1, {(ELEM_W-1){1'b0}}} : {1'b0, {(ELEM_W-1){1'b1}}};
    return w[ELEM_W-1:0];
  endfunction

  always_comb begin
    sum_out = '0;
    for (int i = 0; i < VEC_LEN; i++)
      sum_out[i*ELEM_W +: ELEM_W] = add_elem(a_in[i*ELEM_W +: ELEM_W], b_in[i*ELEM_W +: ELEM_W]);
  end

endmodule

// File: rtl/expmul_sched.sv
// Online-softmax row scheduler: tracks running max m, sequences rescale and
// weight jobs through one expmul unit, and emits the unnormalised row sum O.
//
// state      | meaning
// ACCEPT     | waiting for next (score, V); s_rdy_out high
// ISSUE_R    | offering rescale job exp(m_old - m_new) * O
// WAIT_R     | waiting for rescaled O
// ISSUE_V    | offering weight job exp(s - m_new) * V
// WAIT_V     | waiting for weighted V, accumulate into O
// OUT        | presenting row result until downstream takes it
module expmul_sched
  import expmul_sched_pkg::*;
#(
  parameter bit SKIP_RESCALE = 1'b1,
  parameter bit SAT_ACC      = 1'b1,
  parameter int CNT_W        = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               s_vld_in,
  output logic               s_rdy_out,
  input  logic [INT_W-1:0]   s_score_in,
  input  logic [VEC_W-1:0]   s_v_in,
  input  logic               s_last_in,
  output logic               em_vld_out,
  input  logic               em_rdy_in,
  output logic [INT_W-1:0]   em_a_out,
  output logic [INT_W-1:0]   em_b_out,
  output logic [VEC_W-1:0]   em_vec_out,
  input  logic               em_vld_in,
  output logic               em_rdy_out,
  input  logic [VEC_W-1:0]   em_vec_in,
  output logic               o_vld_out,
  input  logic               o_rdy_in,
  output logic [VEC_W-1:0]   o_vec_out,
  output logic [INT_W-1:0]   o_max_out,
  output logic [CNT_W-1:0]   o_cnt_out
);

  sched_state_e state_q, state_d;
  logic         first_q, first_d;
  logic         last_q, last_d;
  int_t         m_q, m_d, m_new_q, m_new_d, s_q, s_d;
  v_vector_t    v_q, v_d, acc_q, acc_d, acc_base, acc_sum;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic         s_rdy_q, s_rdy_d, em_vld_q, em_vld_d, em_rdy_q, em_rdy_d, o_vld_q, o_vld_d;
  int_t         em_a_q, em_a_d, em_b_q, em_b_d, o_max_q, o_max_d;
  v_vector_t    em_vec_q, em_vec_d, o_vec_q, o_vec_d;
  logic [CNT_W-1:0] o_cnt_q, o_cnt_d;

  // The first V of a row replaces O rather than adding to stale contents.
  assign acc_base = first_q ? '0 : acc_q;

  vec_sat_add #(.SAT(SAT_ACC)) u_add (
    .a_in    (acc_base),
    .b_in    (em_vec_in),
    .sum_out (acc_sum)
  );

  always_comb begin
    state_d = state_q;
    first_d = first_q;
    last_d  = last_q;
    m_d     = m_q;
    m_new_d = m_new_q;
    s_d     = s_q;
    v_d     = v_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_ACCEPT: if (s_vld_in && s_rdy_q) begin
        s_d     = s_score_in;
        v_d     = s_v_in;
        last_d  = s_last_in;
        cnt_d   = cnt_q + 1'b1;
        m_new_d = first_q ? int_t'(s_score_in) : max_signed(m_q, s_score_in);
        state_d = (first_q || (SKIP_RESCALE && (m_new_d == m_q))) ? ST_ISSUE_V : ST_ISSUE_R;
      end
      ST_ISSUE_R: if (em_vld_q && em_rdy_in) state_d = ST_WAIT_R;
      ST_WAIT_R: if (em_vld_in && em_rdy_q) begin
        acc_d   = em_vec_in;
        state_d = ST_ISSUE_V;
      end
      ST_ISSUE_V: if (em_vld_q && em_rdy_in) state_d = ST_WAIT_V;
      ST_WAIT_V: if (em_vld_in && em_rdy_q) begin
        acc_d   = acc_sum;
        m_d     = m_new_q;
        first_d = 1'b0;
        state_d = last_q ? ST_OUT : ST_ACCEPT;
      end
      ST_OUT: if (o_vld_q && o_rdy_in) begin
        first_d = 1'b1;
        acc_d   = '0;
        cnt_d   = '0;
        state_d = ST_ACCEPT;
      end
      default: state_d = ST_ACCEPT;
    endcase

    // Outputs are decoded from the next state so they leave flops directly.
    s_rdy_d  = (state_d == ST_ACCEPT);
    em_vld_d = (state_d == ST_ISSUE_R) || (state_d == ST_ISSUE_V);
    em_rdy_d = (state_d == ST_WAIT_R) || (state_d == ST_WAIT_V);
    o_vld_d  = (state_d == ST_OUT);
    em_a_d   = (state_d == ST_ISSUE_R) ? m_q : (state_d == ST_ISSUE_V) ? s_d : '0;
    em_b_d   = em_vld_d ? m_new_d : '0;
    em_vec_d = (state_d == ST_ISSUE_R) ? acc_d : (state_d == ST_ISSUE_V) ? v_d : '0;
    o_vec_d  = o_vld_d ? acc_d : '0;
    o_max_d  = o_vld_d ? m_d : '0;
    o_cnt_d  = o_vld_d ? cnt_d : '0;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_ACCEPT;
      first_q  <= 1'b1;
      last_q   <= 1'b0;
      m_q      <= '0;
      m_new_q  <= '0;
      s_q      <= '0;
      v_q      <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      s_rdy_q  <= 1'b0;
      em_vld_q <= 1'b0;
      em_rdy_q <= 1'b0;
      o_vld_q  <= 1'b0;
      em_a_q   <= '0;
      em_b_q   <= '0;
      em_vec_q <= '0;
      o_vec_q  <= '0;
      o_max_q  <= '0;
      o_cnt_q  <= '0;
    end else begin
      state_q  <= state_d;
      first_q  <= first_d;
      last_q   <= last_d;
      m_q      <= m_d;
      m_new_q  <= m_new_d;
      s_q      <= s_d;
      v_q      <= v_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      s_rdy_q  <= s_rdy_d;
      em_vld_q <= em_vld_d;
      em_rdy_q <= em_rdy_d;
      o_vld_q  <= o_vld_d;
      em_a_q   <= em_a_d;
      em_b_q   <= em_b_d;
      em_vec_q <= em_vec_d;
      o_vec_q  <= o_vec_d;
      o_max_q  <= o_max_d;
      o_cnt_q  <= o_cnt_d;
    end
  end

  assign s_rdy_out  = s_rdy_q;
  assign em_vld_out = em_vld_q;
  assign em_rdy_out = em_rdy_q;
  assign o_vld_out  = o_vld_q;
  assign em_a_out   = em_a_q;
  assign em_b_out   = em_b_q;
  assign em_vec_out = em_vec_q;
  assign o_vec_out  = o_vec_q;
  assign o_max_out  = o_max_q;
  assign o_cnt_out  = o_cnt_q;

endmodule

// File: tb/tb_expmul_sched.sv
// Directed bench: instance 0 skips rescale and saturates, instance 1 always
// rescales and wraps; each is served by a base-2 expmul model with random timing.
module tb_expmul_sched;

  logic        clk, rst;
  logic        s_vld [2], s_rdy [2], s_last [2];
  logic        em_vld_out [2], em_rdy_in [2], em_vld_in [2], em_rdy_out [2];
  logic        o_vld [2], o_rdy [2];
  logic [7:0]  s_score [2], em_a [2], em_b [2], o_max [2], o_cnt [2];
  logic [31:0] s_v [2], em_vec_out [2], em_vec_in [2], o_vec [2];

  logic        m_busy [2];
  logic [1:0]  m_lat [2];
  logic [7:0]  ja [2][64];
  logic [7:0]  jb [2][64];
  int          jcnt [2];

  int n_cmp = 0;
  int n_bad = 0;

  expmul_sched #(.SKIP_RESCALE(1'b1), .SAT_ACC(1'b1), .CNT_W(8)) u_dut0 (
    .clk(clk), .rst(rst),
    .s_vld_in(s_vld[0]), .s_rdy_out(s_rdy[0]), .s_score_in(s_score[0]), .s_v_in(s_v[0]),
    .s_last_in(s_last[0]),
    .em_vld_out(em_vld_out[0]), .em_rdy_in(em_rdy_in[0]), .em_a_out(em_a[0]), .em_b_out(em_b[0]),
    .em_vec_out(em_vec_out[0]), .em_vld_in(em_vld_in[0]), .em_rdy_out(em_rdy_out[0]),
    .em_vec_in(em_vec_in[0]),
    .o_vld_out(o_vld[0]), .o_rdy_in(o_rdy[0]), .o_vec_out(o_vec[0]), .o_max_out(o_max[0]),
    .o_cnt_out(o_cnt[0])
  );

  expmul_sched #(.SKIP_RESCALE(1'b0), .SAT_ACC(1'b0), .CNT_W(8)) u_dut1 (
    .clk(clk), .rst(rst),
    .s_vld_in(s_vld[1]), .s_rdy_out(s_rdy[1]), .s_score_in(s_score[1]), .s_v_in(s_v[1]),
    .s_last_in(s_last[1]),
    .em_vld_out(em_vld_out[1]), .em_rdy_in(em_rdy_in[1]), .em_a_out(em_a[1]), .em_b_out(em_b[1]),
    .em_vec_out(em_vec_out[1]), .em_vld_in(em_vld_in[1]), .em_rdy_out(em_rdy_out[1]),
    .em_vec_in(em_vec_in[1]),
    .o_vld_out(o_vld[1]), .o_rdy_in(o_rdy[1]), .o_vec_out(o_vec[1]), .o_max_out(o_max[1]),
    .o_cnt_out(o_cnt[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // exp(a-b) approximated as 2^(a-b): each element arithmetic-shifted right by b-a.
  function automatic logic [31:0] expmul(input logic [7:0] a, input logic [7:0] b,
                                         input logic [31:0] v);
    logic [31:0] r;
    int sh;
    sh = int'($signed(b)) - int'($signed(a));
    if (sh < 0) sh = 0;
    if (sh > 7) sh = 7;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*8 +: 8] = 8'($signed(v[i*8 +: 8]) >>> sh);
    return r;
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int k = 0; k < 2; k++) begin
        m_busy[k]    <= 1'b0;
        m_lat[k]     <= 2'd0;
        em_vld_in[k] <= 1'b0;
        em_vec_in[k] <= '0;
        em_rdy_in[k] <= 1'b0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        em_rdy_in[k] <= 1'($urandom_range(0, 1));
        if (em_vld_in[k] && em_rdy_out[k]) begin
          em_vld_in[k] <= 1'b0;
          m_busy[k]    <= 1'b0;
        end else if (m_busy[k] && !em_vld_in[k]) begin
          if (m_lat[k] == 2'd0) em_vld_in[k] <= 1'b1;
          else m_lat[k] <= m_lat[k] - 2'd1;
        end
        if (em_vld_out[k] && em_rdy_in[k]) begin
          m_busy[k]              <= 1'b1;
          m_lat[k]               <= 2'($urandom_range(0, 3));
          em_vec_in[k]           <= expmul(em_a[k], em_b[k], em_vec_out[k]);
          ja[k][jcnt[k] & 63]    <= em_a[k];
          jb[k][jcnt[k] & 63]    <= em_b[k];
          jcnt[k]                <= jcnt[k] + 1;
        end
      end
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input int k, input logic [7:0] s, input logic [31:0] v, input logic last);
    int n = 0;
    @(negedge clk);
    s_vld[k] = 1'b1; s_score[k] = s; s_v[k] = v; s_last[k] = last;
    while (!s_rdy[k] && n < 300) begin @(negedge clk); n++; end
    check("send_timeout", 32'(n < 300), 32'd1);
    @(negedge clk);
    s_vld[k] = 1'b0; s_last[k] = 1'b0;
  endtask

  task automatic get_out(input int k, input string tag, input logic [31:0] ev,
                         input logic [7:0] em, input logic [7:0] ec);
    int n = 0;
    @(negedge clk);
    o_rdy[k] = 1'b1;
    while (!o_vld[k] && n < 500) begin @(negedge clk); n++; end
    check({tag, "_timeout"}, 32'(n < 500), 32'd1);
    check({tag, "_o_vec"}, o_vec[k], ev);
    check({tag, "_o_max"}, 32'(o_max[k]), 32'(em));
    check({tag, "_o_cnt"}, 32'(o_cnt[k]), 32'(ec));
    check({tag, "_s_rdy_excl"}, 32'(s_rdy[k]), 32'd0);
    @(negedge clk);
    o_rdy[k] = 1'b0;
  endtask

  int base0, base1, n;

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      s_vld[k] = 1'b0; s_last[k] = 1'b0; s_score[k] = '0; s_v[k] = '0; o_rdy[k] = 1'b0;
      jcnt[k] = 0;
    end
    #12;
    for (int k = 0; k < 2; k++) begin
      check("rst_s_rdy", 32'(s_rdy[k]), 32'd0);
      check("rst_em_vld", 32'(em_vld_out[k]), 32'd0);
      check("rst_em_rdy", 32'(em_rdy_out[k]), 32'd0);
      check("rst_o_vld", 32'(o_vld[k]), 32'd0);
      check("rst_o_vec", o_vec[k], 32'd0);
      check("rst_em_a", 32'(em_a[k]), 32'd0);
    end
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    check("post_rst_s_rdy", 32'(s_rdy[0]), 32'd1);

    // Single-score row: one V job with a=b=3, O=V.
    base0 = jcnt[0];
    send(0, 8'd3, 32'h0A141E28, 1'b1);
    get_out(0, "t1", 32'h0A141E28, 8'd3, 8'd1);
    check("t1_jobs", 32'(jcnt[0] - base0), 32'd1);
    check("t1_a", 32'(ja[0][base0 & 63]), 32'd3);
    check("t1_b", 32'(jb[0][base0 & 63]), 32'd3);

    // Rising then lower scores: V(1,1) R(1,4) V(4,4) V(2,4); O = 64>>3 + 16 + 32>>2.
    base0 = jcnt[0];
    send(0, 8'd1, 32'h40404040, 1'b0);
    send(0, 8'd4, 32'h10101010, 1'b0);
    send(0, 8'd2, 32'h20202020, 1'b1);
    get_out(0, "t2", 32'h20202020, 8'd4, 8'd3);
    check("t2_jobs", 32'(jcnt[0] - base0), 32'd4);
    check("t2_j0a", 32'(ja[0][(base0 + 0) & 63]), 32'd1);
    check("t2_j0b", 32'(jb[0][(base0 + 0) & 63]), 32'd1);
    check("t2_j1a", 32'(ja[0][(base0 + 1) & 63]), 32'd1);
    check("t2_j1b", 32'(jb[0][(base0 + 1) & 63]), 32'd4);
    check("t2_j2a", 32'(ja[0][(base0 + 2) & 63]), 32'd4);
    check("t2_j2b", 32'(jb[0][(base0 + 2) & 63]), 32'd4);
    check("t2_j3a", 32'(ja[0][(base0 + 3) & 63]), 32'd2);
    check("t2_j3b", 32'(jb[0][(base0 + 3) & 63]), 32'd4);

    // Equal scores: skip variant issues 2 jobs, always-rescale issues 3; same O.
    base0 = jcnt[0];
    send(0, 8'd5, 32'h08080808, 1'b0);
    send(0, 8'd5, 32'h04040404, 1'b1);
    get_out(0, "t3s", 32'h0C0C0C0C, 8'd5, 8'd2);
    check("t3s_jobs", 32'(jcnt[0] - base0), 32'd2);
    base1 = jcnt[1];
    send(1, 8'd5, 32'h08080808, 1'b0);
    send(1, 8'd5, 32'h04040404, 1'b1);
    get_out(1, "t3n", 32'h0C0C0C0C, 8'd5, 8'd2);
    check("t3n_jobs", 32'(jcnt[1] - base1), 32'd3);

    // Output backpressure: result held stable and no new score accepted.
    send(0, 8'd0, 32'h01020304, 1'b1);
    n = 0;
    while (!o_vld[0] && n < 300) begin @(negedge clk); n++; end
    check("t4_timeout", 32'(n < 300), 32'd1);
    for (int i = 0; i < 20; i++) begin
      check("t4_hold_vld", 32'(o_vld[0]), 32'd1);
      check("t4_hold_vec", o_vec[0], 32'h01020304);
      check("t4_hold_cnt", 32'(o_cnt[0]), 32'd1);
      check("t4_hold_s_rdy", 32'(s_rdy[0]), 32'd0);
      @(negedge clk);
    end
    get_out(0, "t4", 32'h01020304, 8'd0, 8'd1);

    // Overflowing accumulation: clamp on instance 0, wrap on instance 1.
    send(0, 8'd0, 32'h807F807F, 1'b0);
    send(0, 8'd0, 32'h807F807F, 1'b1);
    get_out(0, "t5sat", 32'h807F807F, 8'd0, 8'd2);
    send(1, 8'd0, 32'h807F807F, 1'b0);
    send(1, 8'd0, 32'h807F807F, 1'b1);
    get_out(1, "t5wrap", 32'h00FE00FE, 8'd0, 8'd2);

    // Reset while waiting on the rescale result.
    base0 = jcnt[0];
    send(0, 8'd1, 32'h10101010, 1'b0);
    send(0, 8'd3, 32'h10101010, 1'b0);
    n = 0;
    while (!(em_rdy_out[0] && (jcnt[0] == base0 + 2)) && n < 300) begin @(negedge clk); n++; end
    check("t6_reach_wait_r", 32'(n < 300), 32'd1);
    #2 rst = 1'b0;
    #1;
    check("t6_em_vld", 32'(em_vld_out[0]), 32'd0);
    check("t6_em_rdy", 32'(em_rdy_out[0]), 32'd0);
    check("t6_s_rdy", 32'(s_rdy[0]), 32'd0);
    check("t6_o_vld", 32'(o_vld[0]), 32'd0);
    repeat (3) @(negedge clk);
    rst = 1'b1;
    send(0, 8'd7, 32'h11223344, 1'b1);
    get_out(0, "t6", 32'h11223344, 8'd7, 8'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
